// File: rtl/load_store_unit.sv
// load_store_unit: sequences one RV32I load/store into byte/word accesses on a big-endian,
// async-read data memory. Define LSU_BOUNDS_CHECK_EN to also reject accesses beyond MEM_BYTES.
module load_store_unit #(
  parameter int unsigned MEM_BYTES = 1025
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        REQ_VALID,
  output logic        REQ_READY,
  input  logic        REQ_WE,
  input  logic [2:0]  REQ_FUNCT3,
  input  logic [31:0] REQ_ADDR,
  input  logic [31:0] REQ_WDATA,
  output logic        RESP_VALID,
  output logic [31:0] RESP_RDATA,
  output logic        RESP_ERR,
  output logic        MEM_WE,
  output logic [1:0]  MEM_FUNCT3,
  output logic [31:0] MEM_ADDRESS,
  output logic [31:0] MEM_WRITE_DATA,
  input  logic [31:0] MEM_READ_DATA
);

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] MEM_BYTE = 2'd0;
  localparam logic [1:0] MEM_WORD = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_STORE_LO,
    S_RESP
  } state_t;

  state_t      state;
  logic        we_q;
  logic [2:0]  funct3_q;
  logic [31:0] addr_q;
  logic [7:0]  wdata_lo_q;

  logic        resp_valid_q;
  logic [31:0] resp_rdata_q;
  logic        resp_err_q;
  logic        mem_we_q;
  logic [1:0]  mem_funct3_q;
  logic [31:0] mem_addr_q;
  logic [31:0] mem_wdata_q;

  logic        funct3_legal;
  logic        misaligned;
  logic        out_of_range;
  logic        req_err;
  logic [1:0]  size_m1;
  logic [31:0] accept_wdata;
  logic [1:0]  accept_mem_funct3;
  logic [31:0] load_data;

  // Legality and alignment are judged on the live request so the error path needs no memory cycle.
  always_comb begin
    funct3_legal = 1'b0;
    misaligned   = 1'b0;
    case (REQ_FUNCT3)
      F3_B: funct3_legal = 1'b1;
      F3_H: begin
        funct3_legal = 1'b1;
        misaligned   = REQ_ADDR[0];
      end
      F3_W: begin
        funct3_legal = 1'b1;
        misaligned   = |REQ_ADDR[1:0];
      end
      F3_BU: funct3_legal = !REQ_WE;
      F3_HU: begin
        funct3_legal = !REQ_WE;
        misaligned   = REQ_ADDR[0];
      end
      default: funct3_legal = 1'b0;
    endcase
  end

  always_comb begin
    case (REQ_FUNCT3[1:0])
      2'b00:   size_m1 = 2'd0;
      2'b01:   size_m1 = 2'd1;
      default: size_m1 = 2'd3;
    endcase
  end

`ifdef LSU_BOUNDS_CHECK_EN
  logic [32:0] last_byte;

  // 33-bit sum so an access wrapping past 0xFFFFFFFF lands above any memory size.
  always_comb begin
    last_byte    = {1'b0, REQ_ADDR} + {31'd0, size_m1};
    out_of_range = (last_byte >= 33'(MEM_BYTES));
  end
`else
  logic unused_bounds;

  assign unused_bounds = (MEM_BYTES != 0) ^ (|size_m1);
  assign out_of_range  = 1'b0;
`endif

  assign req_err = !funct3_legal || misaligned || out_of_range;

  always_comb begin
    accept_mem_funct3 = MEM_WORD;
    accept_wdata      = 32'd0;
    if (REQ_WE) begin
      case (REQ_FUNCT3)
        F3_W: accept_wdata = REQ_WDATA;
        F3_H: begin
          accept_mem_funct3 = MEM_BYTE;
          accept_wdata      = {24'd0, REQ_WDATA[15:8]};
        end
        default: begin
          accept_mem_funct3 = MEM_BYTE;
          accept_wdata      = {24'd0, REQ_WDATA[7:0]};
        end
      endcase
    end
  end

  // Memory is big-endian: the addressed byte always sits in the top lane of the read word.
  always_comb begin
    case (funct3_q)
      F3_B:    load_data = {{24{MEM_READ_DATA[31]}}, MEM_READ_DATA[31:24]};
      F3_BU:   load_data = {24'd0, MEM_READ_DATA[31:24]};
      F3_H:    load_data = {{16{MEM_READ_DATA[31]}}, MEM_READ_DATA[31:16]};
      F3_HU:   load_data = {16'd0, MEM_READ_DATA[31:16]};
      default: load_data = MEM_READ_DATA;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state        <= S_IDLE;
      we_q         <= 1'b0;
      funct3_q     <= 3'd0;
      addr_q       <= 32'd0;
      wdata_lo_q   <= 8'd0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'd0;
      resp_err_q   <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_funct3_q <= MEM_WORD;
      mem_addr_q   <= 32'd0;
      mem_wdata_q  <= 32'd0;
    end else begin
      resp_valid_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (REQ_VALID) begin
            we_q       <= REQ_WE;
            funct3_q   <= REQ_FUNCT3;
            addr_q     <= REQ_ADDR;
            wdata_lo_q <= REQ_WDATA[7:0];
            mem_addr_q <= REQ_ADDR;
            if (req_err) begin
              state        <= S_RESP;
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
              resp_rdata_q <= 32'd0;
            end else begin
              state        <= S_ACCESS;
              mem_we_q     <= REQ_WE;
              mem_funct3_q <= accept_mem_funct3;
              mem_wdata_q  <= accept_wdata;
            end
          end
        end
        S_ACCESS: begin
          if (we_q && (funct3_q == F3_H)) begin
            // Second half of sh: low byte goes one address up.
            state       <= S_STORE_LO;
            mem_addr_q  <= addr_q + 32'd1;
            mem_wdata_q <= {24'd0, wdata_lo_q};
          end else begin
            state        <= S_RESP;
            resp_valid_q <= 1'b1;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= we_q ? 32'd0 : load_data;
            mem_we_q     <= 1'b0;
            mem_funct3_q <= MEM_WORD;
            mem_addr_q   <= addr_q;
            mem_wdata_q  <= 32'd0;
          end
        end
        S_STORE_LO: begin
          state        <= S_RESP;
          resp_valid_q <= 1'b1;
          resp_err_q   <= 1'b0;
          resp_rdata_q <= 32'd0;
          mem_we_q     <= 1'b0;
          mem_funct3_q <= MEM_WORD;
          mem_addr_q   <= addr_q;
          mem_wdata_q  <= 32'd0;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Reset kills an in-flight write in the same cycle rather than one edge later.
  assign MEM_WE         = mem_we_q && !RST;
  assign MEM_FUNCT3     = mem_funct3_q;
  assign MEM_ADDRESS    = mem_addr_q;
  assign MEM_WRITE_DATA = mem_wdata_q;

  assign REQ_READY  = (state == S_IDLE) && !RST;
  assign RESP_VALID = resp_valid_q;
  assign RESP_RDATA = resp_rdata_q;
  assign RESP_ERR   = resp_err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed scoreboard bench for load_store_unit with a big-endian byte memory model.
module tb_load_store_unit;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        REQ_VALID = 1'b0;
  logic        REQ_READY;
  logic        REQ_WE = 1'b0;
  logic [2:0]  REQ_FUNCT3 = 3'd0;
  logic [31:0] REQ_ADDR = 32'd0;
  logic [31:0] REQ_WDATA = 32'd0;
  logic        RESP_VALID;
  logic [31:0] RESP_RDATA;
  logic        RESP_ERR;
  logic        MEM_WE;
  logic [1:0]  MEM_FUNCT3;
  logic [31:0] MEM_ADDRESS;
  logic [31:0] MEM_WRITE_DATA;
  logic [31:0] MEM_READ_DATA;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } exp_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  f3;
  } wr_t;

  exp_t exp_q[$];
  wr_t  wr_log[$];
  int   total = 0;
  int   bad = 0;

  logic [7:0]  mem [0:2047];
  logic [10:0] ra;

  always #5 CLK = ~CLK;

  load_store_unit #(.MEM_BYTES(1025)) dut (
    .CLK(CLK),
    .RST(RST),
    .REQ_VALID(REQ_VALID),
    .REQ_READY(REQ_READY),
    .REQ_WE(REQ_WE),
    .REQ_FUNCT3(REQ_FUNCT3),
    .REQ_ADDR(REQ_ADDR),
    .REQ_WDATA(REQ_WDATA),
    .RESP_VALID(RESP_VALID),
    .RESP_RDATA(RESP_RDATA),
    .RESP_ERR(RESP_ERR),
    .MEM_WE(MEM_WE),
    .MEM_FUNCT3(MEM_FUNCT3),
    .MEM_ADDRESS(MEM_ADDRESS),
    .MEM_WRITE_DATA(MEM_WRITE_DATA),
    .MEM_READ_DATA(MEM_READ_DATA)
  );

  function automatic logic [7:0] pat(input int i);
    return 8'(i * 7 + 3);
  endfunction

  // Big-endian memory: async read of four bytes, byte or word write on the rising edge.
  assign ra = MEM_ADDRESS[10:0];
  assign MEM_READ_DATA = {mem[ra], mem[ra + 11'd1], mem[ra + 11'd2], mem[ra + 11'd3]};

  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = pat(i);
    forever begin
      @(posedge CLK);
      if (MEM_WE) begin
        if (MEM_FUNCT3 == 2'd0) begin
          mem[ra] <= MEM_WRITE_DATA[7:0];
        end else begin
          mem[ra]         <= MEM_WRITE_DATA[31:24];
          mem[ra + 11'd1] <= MEM_WRITE_DATA[23:16];
          mem[ra + 11'd2] <= MEM_WRITE_DATA[15:8];
          mem[ra + 11'd3] <= MEM_WRITE_DATA[7:0];
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic checkByte(input string tag, input int a, input logic [7:0] expv);
    check32(tag, {24'd0, mem[a]}, {24'd0, expv});
  endtask

  task automatic checkWrite(input string tag, input int idx, input logic [31:0] addr,
                            input logic [31:0] data, input logic [1:0] f3);
    wr_t w;
    w = '0;
    if (wr_log.size() > idx) w = wr_log[idx];
    check32({tag, "_waddr"}, w.addr, addr);
    check32({tag, "_wdata"}, w.data, data);
    check32({tag, "_wf3"}, {30'd0, w.f3}, {30'd0, f3});
  endtask

  task automatic waitReady(input string tag);
    int n;
    n = 0;
    while (!REQ_READY && n < 8) begin
      @(negedge CLK);
      n++;
    end
    check32({tag, "_ready"}, {31'd0, REQ_READY}, 32'd1);
  endtask

  task automatic checkOutput(input string tag, input int lat);
    exp_t e;
    e = exp_q.pop_front();
    check32({tag, "_latency"}, lat, e.lat);
    check32({tag, "_rdata"}, RESP_RDATA, e.rdata);
    check32({tag, "_err"}, {31'd0, RESP_ERR}, {31'd0, e.err});
    check32({tag, "_busy_in_resp"}, {31'd0, REQ_READY}, 32'd0);
  endtask

  task automatic applyStimulus(input string tag, input logic we, input logic [2:0] f3,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [31:0] exp_rdata, input logic exp_err, input int exp_lat);
    exp_t e;
    int   cyc;
    bit   got;
    waitReady(tag);
    e.rdata = exp_rdata;
    e.err   = exp_err;
    e.lat   = exp_lat;
    exp_q.push_back(e);
    wr_log.delete();
    REQ_VALID  = 1'b1;
    REQ_WE     = we;
    REQ_FUNCT3 = f3;
    REQ_ADDR   = addr;
    REQ_WDATA  = wdata;
    @(posedge CLK);
    #1;
    REQ_VALID  = 1'b0;
    REQ_WE     = ~we;
    REQ_FUNCT3 = 3'b111;
    REQ_ADDR   = 32'hDEAD_BEEF;
    REQ_WDATA  = 32'hCAFE_F00D;
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < 10) begin
      @(negedge CLK);
      cyc++;
      if (MEM_WE) wr_log.push_back({MEM_ADDRESS, MEM_WRITE_DATA, MEM_FUNCT3});
      if (RESP_VALID) got = 1'b1;
    end
    check32({tag, "_resp_seen"}, {31'd0, got}, 32'd1);
    if (got) checkOutput(tag, cyc);
    else void'(exp_q.pop_front());
  endtask

  initial begin
    bit saw_resp;

    // Reset state
    repeat (3) @(negedge CLK);
    check32("rst_ready", {31'd0, REQ_READY}, 32'd0);
    check32("rst_resp_valid", {31'd0, RESP_VALID}, 32'd0);
    check32("rst_rdata", RESP_RDATA, 32'd0);
    check32("rst_err", {31'd0, RESP_ERR}, 32'd0);
    check32("rst_mem_we", {31'd0, MEM_WE}, 32'd0);
    check32("rst_mem_f3", {30'd0, MEM_FUNCT3}, 32'd2);
    check32("rst_mem_addr", MEM_ADDRESS, 32'd0);
    check32("rst_mem_wdata", MEM_WRITE_DATA, 32'd0);
    RST = 1'b0;
    #1;
    check32("post_rst_ready", {31'd0, REQ_READY}, 32'd1);
    @(negedge CLK);

    $display("[TB] word store / load");
    applyStimulus("sw_10", 1'b1, 3'b010, 32'h10, 32'h1122_3344, 32'd0, 1'b0, 2);
    checkWrite("sw_10", 0, 32'h10, 32'h1122_3344, 2'd2);
    check32("sw_10_nwrites", wr_log.size(), 32'd1);
    checkByte("sw_10_b0", 'h10, 8'h11);
    checkByte("sw_10_b3", 'h13, 8'h44);
    applyStimulus("lw_10", 1'b0, 3'b010, 32'h10, 32'd0, 32'h1122_3344, 1'b0, 2);
    check32("lw_10_nwrites", wr_log.size(), 32'd0);
    applyStimulus("lb_10", 1'b0, 3'b000, 32'h10, 32'd0, 32'h0000_0011, 1'b0, 2);
    applyStimulus("lh_12", 1'b0, 3'b001, 32'h12, 32'd0, 32'h0000_3344, 1'b0, 2);

    $display("[TB] halfword store split");
    applyStimulus("sh_20", 1'b1, 3'b001, 32'h20, 32'h0000_A5F0, 32'd0, 1'b0, 3);
    check32("sh_20_nwrites", wr_log.size(), 32'd2);
    checkWrite("sh_20_hi", 0, 32'h20, 32'h0000_00A5, 2'd0);
    checkWrite("sh_20_lo", 1, 32'h21, 32'h0000_00F0, 2'd0);
    checkByte("sh_20_b22", 'h22, pat('h22));
    applyStimulus("lh_20", 1'b0, 3'b001, 32'h20, 32'd0, 32'hFFFF_A5F0, 1'b0, 2);
    applyStimulus("lhu_20", 1'b0, 3'b101, 32'h20, 32'd0, 32'h0000_A5F0, 1'b0, 2);

    $display("[TB] byte store / load");
    applyStimulus("sb_31", 1'b1, 3'b000, 32'h31, 32'h1234_5680, 32'd0, 1'b0, 2);
    checkWrite("sb_31", 0, 32'h31, 32'h0000_0080, 2'd0);
    applyStimulus("lb_31", 1'b0, 3'b000, 32'h31, 32'd0, 32'hFFFF_FF80, 1'b0, 2);
    applyStimulus("lbu_31", 1'b0, 3'b100, 32'h31, 32'd0, 32'h0000_0080, 1'b0, 2);
    checkByte("sb_31_b30", 'h30, pat('h30));
    checkByte("sb_31_b32", 'h32, pat('h32));

    $display("[TB] error paths");
    applyStimulus("sw_22_misal", 1'b1, 3'b010, 32'h22, 32'hFFFF_FFFF, 32'd0, 1'b1, 1);
    check32("sw_22_nwrites", wr_log.size(), 32'd0);
    checkByte("sw_22_b22", 'h22, pat('h22));
    applyStimulus("lh_23_misal", 1'b0, 3'b001, 32'h23, 32'd0, 32'd0, 1'b1, 1);
    applyStimulus("ld_f3_011", 1'b0, 3'b011, 32'h10, 32'd0, 32'd0, 1'b1, 1);
    applyStimulus("st_f3_100", 1'b1, 3'b100, 32'h10, 32'h0000_00AA, 32'd0, 1'b1, 1);
    check32("st_f3_100_nwrites", wr_log.size(), 32'd0);
    applyStimulus("lw_after_err", 1'b0, 3'b010, 32'h10, 32'd0, 32'h1122_3344, 1'b0, 2);

    $display("[TB] reset during second byte of sh");
    waitReady("sh_40");
    REQ_VALID  = 1'b1;
    REQ_WE     = 1'b1;
    REQ_FUNCT3 = 3'b001;
    REQ_ADDR   = 32'h40;
    REQ_WDATA  = 32'h0000_C3D4;
    @(posedge CLK);
    #1;
    REQ_VALID = 1'b0;
    saw_resp  = 1'b0;
    @(negedge CLK);
    check32("sh_40_t1_we", {31'd0, MEM_WE}, 32'd1);
    check32("sh_40_t1_addr", MEM_ADDRESS, 32'h40);
    check32("sh_40_t1_data", MEM_WRITE_DATA, 32'h0000_00C3);
    @(negedge CLK);
    check32("sh_40_t2_addr", MEM_ADDRESS, 32'h41);
    saw_resp = saw_resp | RESP_VALID;
    RST = 1'b1;
    #1;
    check32("sh_40_we_gated", {31'd0, MEM_WE}, 32'd0);
    check32("sh_40_ready_in_rst", {31'd0, REQ_READY}, 32'd0);
    @(negedge CLK);
    saw_resp = saw_resp | RESP_VALID;
    check32("sh_40_no_resp", {31'd0, saw_resp}, 32'd0);
    check32("sh_40_rst_rdata", RESP_RDATA, 32'd0);
    check32("sh_40_rst_mem_f3", {30'd0, MEM_FUNCT3}, 32'd2);
    check32("sh_40_rst_mem_addr", MEM_ADDRESS, 32'd0);
    check32("sh_40_rst_mem_wdata", MEM_WRITE_DATA, 32'd0);
    checkByte("sh_40_b40", 'h40, 8'hC3);
    checkByte("sh_40_b41", 'h41, pat('h41));
    RST = 1'b0;
    #1;
    check32("sh_40_ready_after", {31'd0, REQ_READY}, 32'd1);
    @(negedge CLK);
    applyStimulus("lbu_40", 1'b0, 3'b100, 32'h40, 32'd0, 32'h0000_00C3, 1'b0, 2);

    $display("[TB] memory bound");
`ifdef LSU_BOUNDS_CHECK_EN
    applyStimulus("lw_400", 1'b0, 3'b010, 32'h400, 32'd0, 32'd0, 1'b1, 1);
    applyStimulus("lh_400", 1'b0, 3'b001, 32'h400, 32'd0, 32'd0, 1'b1, 1);
    applyStimulus("sw_wrap", 1'b1, 3'b010, 32'hFFFF_FFFC, 32'h1, 32'd0, 1'b1, 1);
    check32("sw_wrap_nwrites", wr_log.size(), 32'd0);
`else
    applyStimulus("lw_400", 1'b0, 3'b010, 32'h400, 32'd0,
                  {pat('h400), pat('h401), pat('h402), pat('h403)}, 1'b0, 2);
`endif
    applyStimulus("lb_400", 1'b0, 3'b000, 32'h400, 32'd0,
                  {{24{pat('h400)}}, pat('h400)} & 32'h0000_00FF | ({32{pat('h400)}} & 32'hFFFF_FF00 & {32{pat('h400) >= 8'h80}}),
                  1'b0, 2);

    check32("scoreboard_empty", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

- Sits between execute stage and `DynamicMemory`; converts one RV32I load/store request into data-memory accesses.
- Memory accepts only word (funct3=2) and byte (funct3=0) writes, is big-endian, and reads asynchronously.
- Block checks alignment and funct3 legality, splits `sh` into two sequenced byte writes, and extracts/extends load data.
- Returns one response pulse per request.

## Interface
Parameters:
- `MEM_BYTES`, 1025, number of addressable bytes in data memory (used only when bounds check compiled in)

Ports:
- `CLK`  input  1  clock, all state updates on rising edge
- `RST`  input  1  synchronous, active-high reset
- `REQ_VALID`  input  1  request present
- `REQ_READY`  output  1  block can accept request (IDLE only)
- `REQ_WE`  input  1  1 = store, 0 = load
- `REQ_FUNCT3`  input  3  RV32I funct3 of the access
- `REQ_ADDR`  input  32  byte address
- `REQ_WDATA`  input  32  store data (rs2)
- `RESP_VALID`  output  1  one-cycle response pulse
- `RESP_RDATA`  output  32  extended load result; 0 for stores/errors
- `RESP_ERR`  output  1  misaligned or illegal access, qualified by `RESP_VALID`
- `MEM_WE`  output  1  to memory `WE`
- `MEM_FUNCT3`  output  2  to memory `funct3`: 0 = byte, 2 = word
- `MEM_ADDRESS`  output  32  to memory `ADDRESS`
- `MEM_WRITE_DATA`  output  32  to memory `WRITE_DATA`
- `MEM_READ_DATA`  input  32  from memory `READ_DATA`; bytes at A..A+3 in [31:24]..[7:0]

## Operation
- States: IDLE, ACCESS, STORE_LO, RESP.
- IDLE:
  - `REQ_READY`=1; accept on `REQ_VALID`; latch WE, funct3, addr, wdata.
  - Error check at accept:
    - Legal loads: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu.
    - Legal stores: 000 sb, 001 sh, 010 sw.
    - Any other funct3 -> error.
    - Halfword with addr[0]≠0 -> error.
    - Word with addr[1:0]≠0 -> error.
  - Error -> RESP with `RESP_ERR`=1; no memory write ever issued.
  - Otherwise -> ACCESS.
- ACCESS:
  - `MEM_ADDRESS`=latched addr.
  - Load: `MEM_WE`=0, `MEM_FUNCT3`=2; capture `MEM_READ_DATA` and extract:
    - lb: sext [31:24]; lbu: zext [31:24]
    - lh: sext [31:16]; lhu: zext [31:16]
    - lw: full word
    - Next state: RESP.
  - sw: `MEM_WE`=1, `MEM_FUNCT3`=2, data=wdata. Next state: RESP.
  - sb: `MEM_WE`=1, `MEM_FUNCT3`=0, data={24'b0, wdata[7:0]}. Next state: RESP.
  - sh: `MEM_WE`=1, `MEM_FUNCT3`=0, data={24'b0, wdata[15:8]} (MSB at lower address). Next state: STORE_LO.
- STORE_LO: `MEM_ADDRESS`=addr+1, `MEM_WE`=1, `MEM_FUNCT3`=0, data={24'b0, wdata[7:0]}. Next state: RESP.
- RESP: `RESP_VALID`=1 for exactly this cycle; `REQ_READY`=0. Next state: IDLE.
- Outside ACCESS/STORE_LO:
  - `MEM_WE`=0, `MEM_FUNCT3`=2, `MEM_ADDRESS`=latched addr, `MEM_WRITE_DATA`=0.
- `RESP_RDATA`, `RESP_ERR` are registered and hold their last value between pulses.
- Address arithmetic is 32-bit modulo; addr+1 wraps at 0xFFFFFFFF.

## Timing
- Handshake: transfer at rising edge with `REQ_VALID`&&`REQ_READY` (cycle T0). Request inputs are don't-care after T0.
- `RESP_VALID` cycle, by access:
  - Error: T1
  - Load, sw, sb: T2
  - sh: T3 (memory writes at ends of T1 and T2)
- No response backpressure. The next request is accepted at earliest the cycle after RESP.
- Reset (RST sampled high at edge):
  - State=IDLE.
  - `RESP_VALID`=0, `RESP_RDATA`=0, `RESP_ERR`=0.
  - `MEM_WE`, `MEM_FUNCT3`, `MEM_ADDRESS`, `MEM_WRITE_DATA` return to their idle values: 0, 2, 0, 0.
- `MEM_WE` is gated combinationally by !`RST`. Reset asserted during STORE_LO suppresses the second byte write (first byte stays written). No response is produced for an aborted request.
- `REQ_READY`=0 while `RST`=1.

## Configuration
- `LSU_BOUNDS_CHECK_EN` defined:
  - Error check also flags addr+size−1 ≥ `MEM_BYTES` (size 1/2/4; computed in 33 bits so wrap counts as out of range).
  - Flagged access behaves exactly like a misaligned one: RESP at T1, `RESP_ERR`=1, no write.
- Undefined: no range check; `MEM_BYTES` unused; addresses pass through unmodified.

## Test plan
- sw addr 0x10 data 0x11223344, then lw 0x10 -> mem[0x10..0x13]=11,22,33,44; load RESP at T2 `RESP_RDATA`=0x11223344, `RESP_ERR`=0.
- sh addr 0x20 data 0x0000A5F0 -> MEM_WE T1 (addr 0x20, data 0xA5) and T2 (addr 0x21, data 0xF0); RESP at T3; then lh 0x20 -> 0xFFFFA5F0, lhu 0x20 -> 0x0000A5F0.
- sb addr 0x31 data 0x80, then lb 0x31 -> 0xFFFFFF80; lbu 0x31 -> 0x00000080; neighbouring byte 0x30 unchanged.
- sw addr 0x22, lh addr 0x23, load funct3 011 -> each RESP at T1 with `RESP_ERR`=1, `RESP_RDATA`=0, `MEM_WE` never asserted.
- sh addr 0x40 with `RST` high during STORE_LO -> byte 0x40 written, 0x41 unchanged, no `RESP_VALID`; all outputs at reset values next cycle; `REQ_READY`=1 after `RST` falls.
- With `LSU_BOUNDS_CHECK_EN`, `MEM_BYTES`=1025: lw 0x400 -> `RESP_ERR`=1, no access; lb 0x400 -> normal RESP. Without macro, lw 0x400 -> no error.
